// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch and buffering stage in front of the decoder. It walks
//   sequential PCs, keeps at most one instruction-memory request in flight,
//   and buffers returned words together with their PCs in a DEPTH-entry FIFO.
//   Flush empties the buffer and redirects fetch. A response that was already
//   in flight at flush time is recognised as stale and dropped. Halt stops new
//   requests until the next flush or reset.
//
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   mem_req_valid/addr/ready      fetch request handshake (addr 4-byte aligned)
//   mem_resp_valid/data           in-order response word
//   out_valid/out_inst/out_pc     head FIFO entry presented to the decoder
//   dec_ready                     decoder consumes the head when out_valid is high
//   flush, flush_pc               discard everything and restart at flush_pc & ~3
//   halt                          stop issuing requests until flush/reset
//   count                         registered FIFO occupancy
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       mem_req_valid,
  output logic [XLEN-1:0]            mem_req_addr,
  input  logic                       mem_req_ready,
  input  logic                       mem_resp_valid,
  input  logic [31:0]                mem_resp_data,
  output logic                       out_valid,
  output logic [31:0]                out_inst,
  output logic [XLEN-1:0]            out_pc,
  input  logic                       dec_ready,
  input  logic                       flush,
  input  logic [XLEN-1:0]            flush_pc,
  input  logic                       halt,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;
  logic             halted_q, halted_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      inst_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem   [DEPTH];

  logic not_full;
  logic req_fire;
  logic resp_fire;
  logic push;
  logic pop;

  // A request is only issued when a slot is free; since nothing else pushes
  // while it is in flight, the matching push can never overflow the FIFO.
  assign not_full      = (count_q != CNT_W'(DEPTH));
  assign mem_req_valid = !reset && !flush && !halted_q && !outstanding_q && not_full;
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses with nothing outstanding are spurious and ignored.
  assign resp_fire = outstanding_q && mem_resp_valid;
  assign push      = resp_fire && !drop_q && !flush;

  assign out_valid = (count_q != '0) && !flush && !reset;
  assign out_inst  = inst_mem[head_q];
  assign out_pc    = pc_mem[head_q];
  assign pop       = out_valid && dec_ready;

  assign count = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    halted_d      = halted_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (flush) begin
      fetch_pc_d = flush_pc & ~(XLEN'(3));
      halted_d   = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      if (outstanding_q && !mem_resp_valid) begin
        // Still waiting on a pre-flush word: keep outstanding set so no new
        // request overtakes it, and mark it for discard when it returns.
        drop_d = 1'b1;
      end else if (resp_fire) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end
    end else begin
      if (halt) begin
        halted_d = 1'b1;
      end
      // req_fire needs !outstanding_q, so it never coincides with resp_fire.
      if (req_fire) begin
        req_pc_d      = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
        outstanding_d = 1'b1;
      end
      if (resp_fire) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      halted_q      <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      halted_q      <= halted_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Buffer storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[tail_q] <= mem_resp_data;
      pc_mem[tail_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed scenarios for fetch_queue. The stimulus process drives inputs and
//   pushes expectations: expected decoder PCs go into exp_q, and per-cycle
//   expectations go into chk_q. A separate monitor process pops and compares
//   on the falling edge, so stimulus and checking stay decoupled. A small
//   memory model answers requests after a programmable latency.
module tb_fetch_queue;

  localparam int K_REQV    = 0;
  localparam int K_ADDR    = 1;
  localparam int K_OUTV    = 2;
  localparam int K_OPC     = 3;
  localparam int K_CNT     = 4;
  localparam int K_SBEMPTY = 5;
  localparam int K_ACC     = 6;
  localparam int K_CNTLE   = 7;

  typedef struct {
    int          at;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  logic        clock;
  logic        reset;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data  = 32'h0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        dec_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        halt;
  logic [3:0]  count;

  fetch_queue dut (
    .clock          (clock),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .dec_ready      (dec_ready),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .halt           (halt),
    .count          (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          cyc_no = 0;
  int          n_run  = 0;
  int          n_fail = 0;
  int          acc_count = 0;
  int          lat = 1;
  bit          sb_en = 1'b0;
  logic [31:0] exp_q[$];
  chk_t        chk_q[$];

  always @(posedge clock) cyc_no <= cyc_no + 1;

  // Instruction word the memory model returns for an address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_REQV:    return "mem_req_valid";
      K_ADDR:    return "mem_req_addr";
      K_OUTV:    return "out_valid";
      K_OPC:     return "out_pc";
      K_CNT:     return "count";
      K_SBEMPTY: return "scoreboard_empty";
      K_ACC:     return "accepted_requests";
      K_CNTLE:   return "count_le_depth";
      default:   return "unknown";
    endcase
  endfunction

  // ---------------- memory model ----------------
  bit          acc_seen = 1'b0;
  bit          rst_seen = 1'b1;
  logic [31:0] acc_addr = 32'h0;
  bit          pend = 1'b0;
  int          remain = 0;
  logic [31:0] pend_addr = 32'h0;

  always @(negedge clock) begin
    acc_seen = mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
    rst_seen = reset;
  end

  always @(posedge clock) begin
    #1;
    mem_resp_valid = 1'b0;
    if (rst_seen) begin
      pend = 1'b0;
    end else begin
      if (acc_seen) begin
        pend      = 1'b1;
        pend_addr = acc_addr;
        remain    = lat;
      end
      if (pend) begin
        if (remain <= 1) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = inst_of(pend_addr);
          pend           = 1'b0;
        end else begin
          remain = remain - 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin : monitor
    chk_t        c;
    logic [31:0] act;
    logic [31:0] e;
    bit          ok;
    while (chk_q.size() > 0 && chk_q[0].at <= cyc_no) begin
      c = chk_q.pop_front();
      case (c.kind)
        K_REQV:    act = {31'b0, mem_req_valid};
        K_ADDR:    act = mem_req_addr;
        K_OUTV:    act = {31'b0, out_valid};
        K_OPC:     act = out_pc;
        K_CNT:     act = {28'b0, count};
        K_SBEMPTY: act = 32'(exp_q.size());
        K_ACC:     act = 32'(acc_count);
        K_CNTLE:   act = {28'b0, count};
        default:   act = 32'hDEAD_BEEF;
      endcase
      ok = (c.kind == K_CNTLE) ? (act <= c.exp) : (act == c.exp);
      n_run++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got 0x%0h, expected %s0x%0h", kname(c.kind), cyc_no,
                 act, (c.kind == K_CNTLE) ? "<= " : "", c.exp);
      end
    end
    if (sb_en && out_valid && dec_ready) begin
      n_run++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop cycle %0d: got pc 0x%0h, expected no output", cyc_no, out_pc);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e) begin
          n_fail++;
          $display("FAIL pop_pc cycle %0d: got 0x%0h, expected 0x%0h", cyc_no, out_pc, e);
        end else begin
          $display("[TB] cycle %0d pop pc=0x%0h inst=0x%0h", cyc_no, out_pc, out_inst);
        end
        n_run++;
        if (out_inst !== inst_of(e)) begin
          n_fail++;
          $display("FAIL pop_inst cycle %0d: got 0x%0h, expected 0x%0h", cyc_no, out_inst, inst_of(e));
        end
      end
    end
    if (mem_req_valid && mem_req_ready) acc_count++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input int kind, input logic [31:0] exp);
    chk_t c;
    c.at   = cyc_no;
    c.kind = kind;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic push_exp(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  // Leaves the caller at the start of cycle 1 after reset release.
  task automatic do_reset(input int l);
    next_cycle();
    reset = 1'b1; flush = 1'b0; halt = 1'b0; dec_ready = 1'b0;
    flush_pc = 32'h0; mem_req_ready = 1'b1; sb_en = 1'b0; lat = l;
    chk(K_SBEMPTY, 32'h0);
    chk(K_REQV, 32'h0);
    chk(K_OUTV, 32'h0);
    next_cycle();
    exp_q.delete();
    chk(K_CNT, 32'h0);
    chk(K_REQV, 32'h0);
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int  base;
    bit  halt_set;
    reset = 1'b1; flush = 1'b0; halt = 1'b0; dec_ready = 1'b0;
    flush_pc = 32'h0; mem_req_ready = 1'b1;

    // 1: sequential fetch, 1-cycle memory, decoder always ready
    do_reset(1);
    sb_en = 1'b1; dec_ready = 1'b1;
    push_exp(32'h0, 6);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) next_cycle();
      case (c)
        1: begin chk(K_REQV, 1); chk(K_ADDR, 32'h0); end
        2: begin chk(K_REQV, 0); chk(K_OUTV, 0); end
        3: begin chk(K_OUTV, 1); chk(K_OPC, 32'h0); chk(K_REQV, 1); chk(K_ADDR, 32'h4); end
        5: chk(K_OPC, 32'h4);
        7: chk(K_OPC, 32'h8);
        default: ;
      endcase
    end

    // 2: backpressure until full, then drain; halt after fetch resumes
    do_reset(1);
    sb_en = 1'b1; base = acc_count;
    for (int c = 1; c <= 45; c++) begin
      if (c > 1) next_cycle();
      case (c)
        1:  begin chk(K_REQV, 1); chk(K_ADDR, 32'h0); end
        17: begin chk(K_CNT, 8); chk(K_REQV, 0); end
        30: begin chk(K_ACC, 32'(base + 8)); chk(K_CNT, 8); chk(K_REQV, 0); push_exp(32'h0, 9); end
        31: begin dec_ready = 1'b1; chk(K_OPC, 32'h0); end
        32: begin chk(K_REQV, 1); chk(K_ADDR, 32'h20); halt = 1'b1; end
        34: chk(K_REQV, 0);
        45: begin chk(K_ACC, 32'(base + 9)); chk(K_CNT, 0); end
        default: ;
      endcase
    end

    // 3: flush with a request in flight, 3-cycle memory, unaligned target
    do_reset(3);
    sb_en = 1'b1; dec_ready = 1'b1;
    push_exp(32'h100, 2);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) next_cycle();
      case (c)
        1: begin chk(K_REQV, 1); chk(K_ADDR, 32'h0); end
        2: begin flush = 1'b1; flush_pc = 32'h102; chk(K_REQV, 0); chk(K_OUTV, 0); end
        3: begin flush = 1'b0; chk(K_REQV, 0); end
        4: begin chk(K_REQV, 0); chk(K_CNT, 0); end
        5: begin chk(K_REQV, 1); chk(K_ADDR, 32'h100); end
        6: chk(K_CNT, 0);
        9: begin chk(K_OUTV, 1); chk(K_OPC, 32'h100); chk(K_CNT, 1); chk(K_ADDR, 32'h104); end
        default: ;
      endcase
    end

    // 4: flush in the same cycle as the response
    do_reset(1);
    sb_en = 1'b1; dec_ready = 1'b1;
    push_exp(32'h200, 2);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) next_cycle();
      case (c)
        1: begin chk(K_REQV, 1); chk(K_ADDR, 32'h0); end
        2: begin flush = 1'b1; flush_pc = 32'h200; chk(K_REQV, 0); end
        3: begin flush = 1'b0; chk(K_CNT, 0); chk(K_REQV, 1); chk(K_ADDR, 32'h200); end
        4: chk(K_CNT, 0);
        5: chk(K_OPC, 32'h200);
        7: chk(K_OPC, 32'h204);
        default: ;
      endcase
    end

    // 5: halt while 0x8 is in flight, then flush+halt together to 0x40
    do_reset(1);
    sb_en = 1'b1; base = acc_count;
    for (int c = 1; c <= 33; c++) begin
      if (c > 1) next_cycle();
      if (c >= 7 && c <= 27) chk(K_REQV, 0);
      case (c)
        5:  chk(K_ADDR, 32'h8);
        6:  halt = 1'b1;
        7:  halt = 1'b0;
        27: begin chk(K_ACC, 32'(base + 3)); chk(K_CNT, 3); chk(K_OUTV, 1); chk(K_OPC, 32'h0); end
        28: begin flush = 1'b1; halt = 1'b1; flush_pc = 32'h40; chk(K_OUTV, 0); push_exp(32'h40, 2); end
        29: begin flush = 1'b0; halt = 1'b0; dec_ready = 1'b1;
                  chk(K_CNT, 0); chk(K_REQV, 1); chk(K_ADDR, 32'h40); end
        31: chk(K_OPC, 32'h40);
        33: chk(K_OPC, 32'h44);
        default: ;
      endcase
    end

    // 6: 20 instructions through the FIFO with dec_ready toggling
    do_reset(1);
    sb_en = 1'b1; base = acc_count; halt_set = 1'b0;
    push_exp(32'h0, 20);
    for (int c = 1; c <= 120; c++) begin
      if (c > 1) next_cycle();
      dec_ready = (c % 2 == 1);
      if (!halt_set && (acc_count - base) >= 20) begin
        halt = 1'b1;
        halt_set = 1'b1;
      end
      chk(K_CNTLE, 32'd8);
      if (c == 120) begin chk(K_ACC, 32'(base + 20)); chk(K_CNT, 0); end
    end

    do_reset(1);
    next_cycle();
    next_cycle();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
